// File: rtl/gray_step_ctrl_pkg.sv
// Shared definitions for the gray counter sequencer: state encoding and gray width.
package gray_step_ctrl_pkg;

    localparam int GRAY_W = 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_CLR  = S_CLR,
        ST_RUN  = S_RUN,
        ST_HOLD = S_HOLD,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/gray_step_ctrl_shadow.sv
// Binary shadow of the gray counter phase: wrap detection, saturating wrap count
// and the gray code the real counter is expected to show.
module gray_shadow
    import gray_step_ctrl_pkg::*;
#(
    parameter int WRAP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              clr,
    input  logic              step,
    output logic [GRAY_W-1:0] exp_gray,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_seen
);

    logic [GRAY_W-1:0] phase_reg, phase_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic              wrap_seen_reg, wrap_seen_next;

    // Advance the phase on every enabled step; a step out of all-ones is a wrap.
    always_comb begin
        phase_next     = phase_reg;
        wrap_cnt_next  = wrap_cnt_reg;
        wrap_seen_next = wrap_seen_reg;
        if (clr) begin
            phase_next     = '0;
            wrap_cnt_next  = '0;
            wrap_seen_next = 1'b0;
        end else if (step) begin
            phase_next = phase_reg + 1'b1;
            if (phase_reg == '1) begin
                wrap_seen_next = 1'b1;
                if (wrap_cnt_reg != '1) begin
                    wrap_cnt_next = wrap_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Shadow state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_reg     <= '0;
            wrap_cnt_reg  <= '0;
            wrap_seen_reg <= 1'b0;
        end else begin
            phase_reg     <= phase_next;
            wrap_cnt_reg  <= wrap_cnt_next;
            wrap_seen_reg <= wrap_seen_next;
        end
    end

    // Binary to gray: each lower bit is the XOR of adjacent phase bits.
    genvar gi;
    generate
        for (gi = 0; gi < GRAY_W - 1; gi++) begin : g_gray
            assign exp_gray[gi] = phase_reg[gi+1] ^ phase_reg[gi];
        end
    endgenerate
    assign exp_gray[GRAY_W-1] = phase_reg[GRAY_W-1];

    assign wrap_cnt  = wrap_cnt_reg;
    assign wrap_seen = wrap_seen_reg;

endmodule

// File: rtl/gray_step_ctrl.sv
// Sequencer for one 3-bit gray counter: issues exactly Steps enables with optional
// pre-clear, pause and abort, and cross-checks the counter's sticky overflow.
module gray_step_ctrl
    import gray_step_ctrl_pkg::*;
#(
    parameter int STEP_W = 8,
    parameter int WRAP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [STEP_W-1:0] Steps,
    input  logic              Clr_req,
    input  logic              Pause,
    input  logic              Abort,
    input  logic              Ovf_in,
    output logic              Cnt_En,
    output logic              Cnt_Clr,
    output logic              Busy,
    output logic              Done,
    output logic [STEP_W-1:0] Remaining,
    output logic [GRAY_W-1:0] Exp_gray,
    output logic [WRAP_W-1:0] Wrap_cnt,
    output logic              Err
);

    state_t            state_reg, state_next;
    logic [STEP_W-1:0] rem_reg, rem_next;
    logic              err_reg, err_next;
    logic              wrap_seen;

    // Next-state, remaining count and counter strobes.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        Cnt_En     = 1'b0;
        Cnt_Clr    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    rem_next = Steps;
                    if (Steps == '0) begin
                        state_next = ST_DONE;
                    end else if (Clr_req) begin
                        state_next = ST_CLR;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_CLR: begin
                Busy       = 1'b1;
                Cnt_Clr    = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                Busy   = 1'b1;
                Cnt_En = !Pause && !Abort;
                if (Abort) begin
                    state_next = ST_DONE;
                end else if (Pause) begin
                    state_next = ST_HOLD;
                end else begin
                    rem_next = rem_reg - STEP_W'(1);
                    // Last step issued this cycle: finish without another enable.
                    if (rem_reg == STEP_W'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                Busy = 1'b1;
                if (Abort) begin
                    state_next = ST_DONE;
                end else if (!Pause) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                Done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Overflow cross-check: sticky, cleared only by the pre-clear cycle.
    always_comb begin
        err_next = err_reg | (Ovf_in ^ wrap_seen);
        if (state_reg == ST_CLR) begin
            err_next = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            rem_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            err_reg   <= err_next;
        end
    end

    gray_shadow #(
        .WRAP_W (WRAP_W)
    ) u_shadow (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clr       (Cnt_Clr),
        .step      (Cnt_En),
        .exp_gray  (Exp_gray),
        .wrap_cnt  (Wrap_cnt),
        .wrap_seen (wrap_seen)
    );

    assign Remaining = rem_reg;
    assign Err       = err_reg;

endmodule
